// File: rtl/vga_pkg.sv
// Shared definitions for the VGA player blocks.
//   KEY_W        decoded key code that requests a jump
//   SOLID_COLOR  map ROM value that marks a solid tile
//   Y_MAX        lowest pixel row the player's feet may reach
//   mode_e       vertical motion mode of the player
//   probe_e      phases of one map ROM probe
//   make_adr     builds a map ROM address from pixel coordinates
package vga_pkg;

  localparam logic [3:0]  KEY_W       = 4'h1;
  localparam logic [3:0]  SOLID_COLOR = 4'h0;
  localparam logic [10:0] Y_MAX       = 11'd767;

  typedef enum logic [1:0] {
    MODE_GROUND = 2'd0,
    MODE_RISE   = 2'd1,
    MODE_FALL   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    PRB_WAIT   = 2'd0,
    PRB_ADDR   = 2'd1,
    PRB_SAMPLE = 2'd2
  } probe_e;

  // The map is stored in 4x4 pixel tiles: row tile in [15:9], column tile in [8:0].
  function automatic logic [15:0] make_adr(input logic [10:0] py, input logic [10:0] xp);
    make_adr = {7'(py >> 2), 9'(xp >> 2)};
  endfunction

endpackage

// File: rtl/player_jump_if.sv
// Signal bundle between the jump block and its surroundings.
//   key          decoded key code
//   player_xpos  horizontal position of the player
//   rgb_pixel    map ROM read data (one-cycle latency)
//   pixel_adr    map ROM read address
//   ypos         top edge of the player
//   airborne     high while rising or falling
// master: the surroundings (key decoder, player_control, map ROM)
// slave:  player_jump
interface player_jump_if;
  logic [3:0]  key;
  logic [10:0] player_xpos;
  logic [3:0]  rgb_pixel;
  logic [15:0] pixel_adr;
  logic [9:0]  ypos;
  logic        airborne;

  modport master (
    output key,
    output player_xpos,
    output rgb_pixel,
    input  pixel_adr,
    input  ypos,
    input  airborne
  );

  modport slave (
    input  key,
    input  player_xpos,
    input  rgb_pixel,
    output pixel_adr,
    output ypos,
    output airborne
  );
endinterface

// File: rtl/player_jump_step_timer.sv
// Free-running step counter for the player's vertical motion.
//   clk   system clock
//   rst   asynchronous active-high reset
//   tick  one-cycle pulse on the cycle the counter wraps to 0
module step_timer #(
  parameter int STEP_TICKS = 500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/player_jump.sv
// Vertical motion of the player: jump, rise, fall and landing against the map.
// Every step pulse launches one map ROM probe at the player's head (while
// rising) or feet (otherwise); the sampled tile decides the next mode and the
// one-pixel ypos update.
//   clk    system clock
//   rst    asynchronous active-high reset
//   bus    player_jump_if.slave: key, player_xpos, rgb_pixel in;
//          pixel_adr, ypos, airborne out
module player_jump
  import vga_pkg::*;
#(
  parameter int STEP_TICKS  = 500000,
  parameter int JUMP_HEIGHT = 48,
  parameter int PLAYER_H    = 32,
  parameter int Y_START     = 100
) (
  input  logic          clk,
  input  logic          rst,
  player_jump_if.slave  bus
);

  localparam int RC_W = $clog2(JUMP_HEIGHT + 1);

  logic            tick;
  mode_e           mode_q,     mode_d;
  probe_e          probe_q,    probe_d;
  logic [RC_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [9:0]      ypos_q,     ypos_d;
  logic [15:0]     adr_q,      adr_d;

  logic [10:0]     foot_y;
  logic [10:0]     head_y;
  logic [10:0]     probe_y;
  logic            solid;

  step_timer #(
    .STEP_TICKS (STEP_TICKS)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // 11-bit probe rows so that ypos+PLAYER_H near the bottom cannot wrap.
  assign foot_y  = {1'b0, ypos_q} + 11'(PLAYER_H);
  assign head_y  = {1'b0, ypos_q} - 11'd1;
  assign probe_y = (mode_q == MODE_RISE) ? head_y : foot_y;
  assign solid   = (bus.rgb_pixel == SOLID_COLOR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_GROUND;
      probe_q    <= PRB_WAIT;
      rise_cnt_q <= '0;
      ypos_q     <= 10'(Y_START);
      adr_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      probe_q    <= probe_d;
      rise_cnt_q <= rise_cnt_d;
      ypos_q     <= ypos_d;
      adr_q      <= adr_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    probe_d    = probe_q;
    rise_cnt_d = rise_cnt_q;
    ypos_d     = ypos_q;
    adr_d      = adr_q;
    case (probe_q)
      PRB_WAIT: begin
        // Step pulses outside WAIT fall through the other arms untouched.
        if (tick) begin
          if ((mode_q == MODE_GROUND) && (bus.key == KEY_W)) begin
            mode_d     = MODE_RISE;
            rise_cnt_d = '0;
          end else begin
            // The address is loaded as ADDR is entered so it is stable for the
            // whole ADDR cycle; the ROM registers it at the end of ADDR and its
            // data is valid throughout SAMPLE.
            probe_d = PRB_ADDR;
            adr_d   = make_adr(probe_y, bus.player_xpos);
          end
        end
      end
      PRB_ADDR: begin
        probe_d = PRB_SAMPLE;
      end
      PRB_SAMPLE: begin
        probe_d = PRB_WAIT;
        case (mode_q)
          MODE_GROUND: begin
            if (!solid) mode_d = MODE_FALL;
          end
          MODE_RISE: begin
            if (solid || (ypos_q == '0) || (rise_cnt_q == RC_W'(JUMP_HEIGHT))) begin
              mode_d = MODE_FALL;
            end else begin
              ypos_d     = ypos_q - 10'd1;
              rise_cnt_d = rise_cnt_q + 1'b1;
            end
          end
          MODE_FALL: begin
            if (solid || (foot_y == Y_MAX)) begin
              mode_d = MODE_GROUND;
            end else begin
              ypos_d = ypos_q + 10'd1;
            end
          end
          default: mode_d = MODE_GROUND;
        endcase
      end
      default: probe_d = PRB_WAIT;
    endcase
  end

  always_comb begin
    bus.pixel_adr = adr_q;
    bus.ypos      = ypos_q;
    bus.airborne  = (mode_q != MODE_GROUND);
  end

endmodule

// File: tb/tb_player_jump.sv
// Directed bench for player_jump with STEP_TICKS=4 and a small tile map model.
module tb_player_jump;
  import vga_pkg::*;

  localparam logic [15:0] ADR_33_100 = {7'd33, 9'd100};
  localparam logic [15:0] ADR_33_200 = {7'd33, 9'd200};
  localparam logic [15:0] ADR_24_200 = {7'd24, 9'd200};
  localparam logic [15:0] ADR_17_100 = {7'd17, 9'd100};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  // 0: all solid, 1: floor at row tiles >= 33 (pixel rows >= 132),
  // 2: floor plus ceiling at row tiles <= 22 (pixel rows <= 91), 3: empty
  int   map_sel = 0;

  player_jump_if pj_if ();

  player_jump #(
    .STEP_TICKS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (pj_if)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_data(input logic [15:0] adr);
    logic [6:0] row;
    row = adr[15:9];
    case (map_sel)
      0:       rom_data = 4'h0;
      1:       rom_data = (row >= 7'd33) ? 4'h0 : 4'hF;
      2:       rom_data = ((row >= 7'd33) || (row <= 7'd22)) ? 4'h0 : 4'hF;
      default: rom_data = 4'hF;
    endcase
  endfunction

  // Synchronous map ROM, one cycle of read latency.
  always @(posedge clk) pj_if.rgb_pixel <= rom_data(pj_if.pixel_adr);

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ends on a negedge with rst just released; step pulses then land on the
  // 4th, 8th, ... rising edges after release.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    map_sel = 0;
    pj_if.key = 4'h0;
    pj_if.player_xpos = 11'd400;
    rst = 1'b1;
    cyc(3);
    vectors++;
    if (pj_if.ypos !== 10'd100) begin
      miscompares++; $display("FAIL reset_ypos: got %0d, want 100", pj_if.ypos);
    end
    vectors++;
    if (pj_if.airborne !== 1'b0) begin
      miscompares++; $display("FAIL reset_airborne: got %0b, want 0", pj_if.airborne);
    end
    vectors++;
    if (pj_if.pixel_adr !== 16'h0000) begin
      miscompares++; $display("FAIL reset_adr: got %h, want 0000", pj_if.pixel_adr);
    end
    rst = 1'b0;
  endtask

  task automatic test_probe_address();
    map_sel = 1;
    pj_if.key = 4'h0;
    pj_if.player_xpos = 11'd400;
    do_reset();
    cyc(3);
    vectors++;
    if (pj_if.pixel_adr !== 16'h0000) begin
      miscompares++; $display("FAIL adr_before_step: got %h, want 0000", pj_if.pixel_adr);
    end
    cyc(1);
    vectors++;
    if (pj_if.pixel_adr !== ADR_33_100) begin
      miscompares++; $display("FAIL adr_foot: got %h, want %h", pj_if.pixel_adr, ADR_33_100);
    end
    pj_if.player_xpos = 11'd800;
    cyc(2);
    vectors++;
    if (pj_if.pixel_adr !== ADR_33_100) begin
      miscompares++; $display("FAIL adr_latched: got %h, want %h", pj_if.pixel_adr, ADR_33_100);
    end
    cyc(2);
    vectors++;
    if (pj_if.pixel_adr !== ADR_33_200) begin
      miscompares++; $display("FAIL adr_new_x: got %h, want %h", pj_if.pixel_adr, ADR_33_200);
    end
    pj_if.key = KEY_W;
    cyc(4);
    pj_if.key = 4'h0;
    vectors++;
    if ((pj_if.airborne !== 1'b1) || (pj_if.pixel_adr !== ADR_33_200)) begin
      miscompares++;
      $display("FAIL jump_no_probe: got air=%0b adr=%h, want air=1 adr=%h",
               pj_if.airborne, pj_if.pixel_adr, ADR_33_200);
    end
    cyc(4);
    vectors++;
    if (pj_if.pixel_adr !== ADR_24_200) begin
      miscompares++; $display("FAIL adr_head: got %h, want %h", pj_if.pixel_adr, ADR_24_200);
    end
    cyc(2);
    vectors++;
    if (pj_if.ypos !== 10'd99) begin
      miscompares++; $display("FAIL first_rise: got %0d, want 99", pj_if.ypos);
    end
  endtask

  task automatic test_idle_ground();
    int bad;
    map_sel = 0;
    pj_if.key = 4'h0;
    pj_if.player_xpos = 11'd400;
    do_reset();
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ((pj_if.ypos !== 10'd100) || (pj_if.airborne !== 1'b0)) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL idle_ground: got %0d bad cycles, want 0", bad);
    end
  endtask

  // One jump with a one-step key press; returns the apex and whether it landed.
  task automatic run_jump(input int map, output int apex, output bit landed);
    bit seen_air;
    map_sel = map;
    pj_if.key = 4'h0;
    pj_if.player_xpos = 11'd400;
    do_reset();
    cyc(8);
    pj_if.key = KEY_W;
    cyc(4);
    pj_if.key = 4'h0;
    apex = 1023;
    seen_air = 1'b0;
    landed = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (pj_if.airborne === 1'b1) seen_air = 1'b1;
      if (int'(pj_if.ypos) < apex) apex = int'(pj_if.ypos);
      if (seen_air && (pj_if.airborne === 1'b0)) begin
        landed = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_jump();
    int apex;
    bit landed;
    run_jump(1, apex, landed);
    vectors++;
    if (apex != 52) begin
      miscompares++; $display("FAIL jump_apex: got %0d, want 52", apex);
    end
    vectors++;
    if (!landed || (pj_if.ypos !== 10'd100)) begin
      miscompares++; $display("FAIL jump_land: got landed=%0b ypos=%0d, want 1 and 100", landed, pj_if.ypos);
    end
    cyc(40);
    vectors++;
    if ((pj_if.airborne !== 1'b0) || (pj_if.ypos !== 10'd100)) begin
      miscompares++;
      $display("FAIL jump_rest: got air=%0b ypos=%0d, want 0 and 100", pj_if.airborne, pj_if.ypos);
    end
  endtask

  task automatic test_ceiling();
    int apex;
    bit landed;
    // Ceiling tiles cover pixel rows up to 91: the head probe at row 91 hits at ypos 92.
    run_jump(2, apex, landed);
    vectors++;
    if (apex != 92) begin
      miscompares++; $display("FAIL ceiling_apex: got %0d, want 92", apex);
    end
    vectors++;
    if (!landed || (pj_if.ypos !== 10'd100)) begin
      miscompares++; $display("FAIL ceiling_land: got landed=%0b ypos=%0d, want 1 and 100", landed, pj_if.ypos);
    end
  endtask

  task automatic test_held_key();
    int apex;
    bit seen_air;
    bit landed;
    bit rejump;
    map_sel = 1;
    pj_if.player_xpos = 11'd400;
    pj_if.key = 4'h0;
    do_reset();
    pj_if.key = KEY_W;
    apex = 1023;
    seen_air = 1'b0;
    landed = 1'b0;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (pj_if.airborne === 1'b1) seen_air = 1'b1;
      if (int'(pj_if.ypos) < apex) apex = int'(pj_if.ypos);
      if (seen_air && (pj_if.airborne === 1'b0)) begin
        landed = 1'b1;
        break;
      end
    end
    vectors++;
    if (apex != 52) begin
      miscompares++; $display("FAIL held_apex: got %0d, want 52", apex);
    end
    vectors++;
    if (!landed || (pj_if.ypos !== 10'd100)) begin
      miscompares++; $display("FAIL held_land: got landed=%0b ypos=%0d, want 1 and 100", landed, pj_if.ypos);
    end
    rejump = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (pj_if.ypos === 10'd99) begin
        rejump = 1'b1;
        break;
      end
    end
    vectors++;
    if (!rejump) begin
      miscompares++; $display("FAIL held_rejump: got ypos=%0d, want 99 within 12 cycles", pj_if.ypos);
    end
    pj_if.key = 4'h0;
  endtask

  task automatic test_free_fall();
    int  top;
    bit  reached;
    bit  grounded;
    map_sel = 3;
    pj_if.key = 4'h0;
    pj_if.player_xpos = 11'd400;
    do_reset();
    top = 0;
    reached = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (int'(pj_if.ypos) > top) top = int'(pj_if.ypos);
      if (pj_if.ypos === 10'd735) begin
        reached = 1'b1;
        break;
      end
    end
    vectors++;
    if (!reached) begin
      miscompares++; $display("FAIL fall_reach: got ypos=%0d, want 735", pj_if.ypos);
    end
    grounded = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (int'(pj_if.ypos) > top) top = int'(pj_if.ypos);
      if (pj_if.airborne === 1'b0) grounded = 1'b1;
    end
    vectors++;
    if (top != 735) begin
      miscompares++; $display("FAIL fall_bottom: got max ypos %0d, want 735", top);
    end
    vectors++;
    if (!grounded) begin
      miscompares++; $display("FAIL fall_ground: got airborne stuck at 1, want a GROUND cycle");
    end
  endtask

  task automatic test_reset_mid_jump();
    bit hit;
    map_sel = 1;
    pj_if.key = 4'h0;
    pj_if.player_xpos = 11'd400;
    do_reset();
    cyc(8);
    pj_if.key = KEY_W;
    cyc(4);
    pj_if.key = 4'h0;
    hit = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (pj_if.ypos === 10'd70) begin
        hit = 1'b1;
        break;
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++; $display("FAIL rise_to_70: got ypos=%0d, want 70", pj_if.ypos);
    end
    cyc(2);
    vectors++;
    if (pj_if.pixel_adr !== ADR_17_100) begin
      miscompares++; $display("FAIL mid_probe_adr: got %h, want %h", pj_if.pixel_adr, ADR_17_100);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ((pj_if.ypos !== 10'd100) || (pj_if.airborne !== 1'b0) || (pj_if.pixel_adr !== 16'h0000)) begin
      miscompares++;
      $display("FAIL async_reset: got ypos=%0d air=%0b adr=%h, want 100 0 0000",
               pj_if.ypos, pj_if.airborne, pj_if.pixel_adr);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if ((pj_if.ypos !== 10'd100) || (pj_if.airborne !== 1'b0)) begin
      miscompares++;
      $display("FAIL after_reset_edge: got ypos=%0d air=%0b, want 100 0", pj_if.ypos, pj_if.airborne);
    end
  endtask

  initial begin
    pj_if.key = 4'h0;
    pj_if.player_xpos = 11'd400;
    test_reset();
    test_probe_address();
    test_idle_ground();
    test_jump();
    test_ceiling();
    test_held_key();
    test_free_fall();
    test_reset_mid_jump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
